esc_multi: RTL and testbench
============================

Name: esc_multi

Overview:
- Parametrised successor to the single-channel ESC PWM generator.
- Drives NCH ESC pulse outputs from one shared frame counter on the 1 MHz timer clock.
- Per-channel values are written over a simple write port. They are double-buffered and applied only at frame boundaries, so pulses never glitch.
- Adds arm/disarm control and a command-loss watchdog that forces all channels to minimum throttle.

Parameters:
NCH, 4, number of output channels (1..16)
VAL_W, 10, command value width
PERIOD, 2500, frame length in clock cycles (2500 = 400 Hz at 1 MHz)
PULSE_MIN, 988, pulse width in cycles for value 0
TIMEOUT_FRAMES, 40, frames without a valid write before failsafe; 0 disables the watchdog

Ports:
tmr_1Mhz  in  1  clock, 1 MHz timer tick
rst  in  1  synchronous reset, active-low
arm  in  1  level; 1 requests outputs enabled
wr_en  in  1  write strobe, one cycle per write
wr_ch  in  $clog2(NCH) (min 1)  target channel
wr_val  in  VAL_W  command value
sig  out  NCH  pulse outputs, bit i = channel i
frame_tick  out  1  one-cycle pulse at the start of each frame
armed  out  1  1 while in ARMED or FAILSAFE
failsafe  out  1  1 while in FAILSAFE

Behaviour:
- Reset (rst==0 at a clock edge):
  - ctr=0.
  - All pending and active values = 0.
  - state=DISARMED, watchdog frame count=0.
  - sig=0, frame_tick=0, armed=0, failsafe=0.
- Counter:
  - ctr counts 0..PERIOD-1 and wraps to 0. It free-runs in every state.
  - "Boundary" is the cycle with ctr==PERIOD-1.
- Write port:
  - wr_en with wr_ch<NCH loads pending[wr_ch]=wr_val on the next edge.
  - wr_ch>=NCH is ignored and does not feed the watchdog.
  - At the boundary, active[i] loads pending[i] for every channel.
  - A write on the boundary cycle itself is bypassed into active, so it is used by the frame that starts next.
- Pulse width:
  - width_i = PULSE_MIN + active[i], computed at VAL_W+12 bits with no overflow.
  - If width_i > PERIOD-1, width_i is clamped to PERIOD-1, so there is at least one low cycle per frame.
  - Combinational high_i = (ctr < width_i) and output enabled.
  - sig[i] is high_i registered, i.e. one cycle latency after ctr.
  - Defaults give 988..2011 cycles (us).
- frame_tick: registered, high for exactly one cycle, coincident with the first cycle of sig high in a frame (the cycle after ctr==0).
- State machine:
  - DISARMED: outputs enabled=0, sig all low. If arm==1 at the boundary, go to ARMED.
  - ARMED: outputs use active values. Watchdog count is cleared by any valid write and otherwise incremented at each boundary. When TIMEOUT_FRAMES>0 and the count reaches TIMEOUT_FRAMES, go to FAILSAFE at that boundary.
  - FAILSAFE: outputs enabled, every channel emits PULSE_MIN. On entry all pending and active values are cleared to 0. A valid write returns the state to ARMED on the next edge and clears the count; the written value takes effect at the next boundary.
  - arm==0 in any state: go to DISARMED on the next edge. sig goes low one cycle later, even mid-pulse. Disarm is immediate; arm is frame-aligned.
- Simultaneous events:
  - Write and timeout on the same boundary: the write wins and the state stays ARMED.
  - arm falling and timeout together: DISARMED wins.
- Watchdog count saturates at TIMEOUT_FRAMES. It is held at 0 in DISARMED.

Test Plan:
- Reset, then hold rst low for 3 cycles → sig=0, flags=0, ctr restarts at 0 after release. Release rst, arm=0 → sig all 0 for 3 frames, frame_tick every 2500 cycles.
- arm=1 mid-frame, write ch0=0, ch1=1023, ch2=512 → nothing until the next boundary. From then on, pulses of 988, 2011 and 1500 cycles every 2500 cycles. ch3 runs at 988.
- Write ch1=100 at ctr=500, then ch1=200 at ctr=2499 → the current frame keeps its old width; the next frame is 1188 (bypass of the boundary-cycle write).
- Parameter run PULSE_MIN=2400, VAL_W=10, val=1023 → pulse clamped to 2499 high, 1 low. Write wr_ch=7 with NCH=4 → ignored, no watchdog refresh.
- Armed, with no writes for 40 frames → failsafe=1 at the 40th boundary and all sig at 988. A later write of ch0=300 → failsafe=0, ch0=1288 from the next frame.
- Drop arm at ctr=400 while a 1500-cycle pulse is high → sig low by ctr=402 and armed=0. Re-arm at ctr=1000 → pulses resume only from the next frame.

Source files
------------

// File: rtl/esc_multi.sv
// Multi-channel ESC pulse generator: one shared frame counter drives NCH pulse
// outputs from double-buffered values, with frame-aligned arming and a failsafe.
module esc_multi #(
    parameter int NCH            = 4,
    parameter int VAL_W          = 10,
    parameter int PERIOD         = 2500,
    parameter int PULSE_MIN      = 988,
    parameter int TIMEOUT_FRAMES = 40,
    localparam int CH_W          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             tmr_1Mhz,
    input  logic             rst,
    input  logic             arm,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [VAL_W-1:0] wr_val,
    output logic [NCH-1:0]   sig,
    output logic             frame_tick,
    output logic             armed,
    output logic             failsafe
);

    localparam int CTR_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WIDTH_W = VAL_W + 12;
    localparam int CMP_W   = (CTR_W > WIDTH_W) ? CTR_W : WIDTH_W;
    localparam int WD_W    = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(PERIOD - 1);
    localparam logic [CMP_W-1:0] W_MIN    = CMP_W'(PULSE_MIN);
    localparam logic [CMP_W-1:0] W_MAX    = CMP_W'(PERIOD - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_FRAMES);
    localparam bit               WD_ON    = (TIMEOUT_FRAMES > 0);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_FAILSAFE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CTR_W-1:0]  ctr;
    logic              boundary;
    logic              wr_ok;
    logic [NCH-1:0]    wr_hit;
    logic [VAL_W-1:0]  pending [NCH];
    logic [VAL_W-1:0]  active  [NCH];
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_nx;
    logic [WD_W-1:0]   wd_inc;
    logic              clear_vals;
    logic              out_en;
    logic              out_fs;
    logic [NCH-1:0]    high;

    assign boundary = (ctr == CTR_LAST);

    // Frame counter free-runs regardless of arm state.
    always_ff @(posedge tmr_1Mhz) begin
        if (!rst) begin
            ctr <= '0;
        end else if (boundary) begin
            ctr <= '0;
        end else begin
            ctr <= ctr + CTR_W'(1);
        end
    end

    always_comb begin
        wr_ok  = wr_en && (32'(wr_ch) < NCH);
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = wr_ok && (32'(wr_ch) == i);
        end
    end

    assign wd_inc = (WD_ON && (wd_cnt != WD_LIMIT)) ? wd_cnt + WD_W'(1) : wd_cnt;

    always_ff @(posedge tmr_1Mhz) begin
        if (!rst) begin
            state  <= S_DISARMED;
            wd_cnt <= '0;
        end else begin
            state  <= state_nx;
            wd_cnt <= wd_nx;
        end
    end

    // Arming waits for a frame boundary; disarming overrides everything at once.
    always_comb begin
        state_nx   = state;
        wd_nx      = wd_cnt;
        clear_vals = 1'b0;
        case (state)
            S_DISARMED: begin
                wd_nx = '0;
                if (boundary && arm) begin
                    state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (wr_ok) begin
                    wd_nx = '0;
                end else if (boundary) begin
                    wd_nx = wd_inc;
                    if (WD_ON && (wd_inc == WD_LIMIT)) begin
                        state_nx   = S_FAILSAFE;
                        clear_vals = 1'b1;
                    end
                end
            end
            S_FAILSAFE: begin
                if (wr_ok) begin
                    state_nx = S_ARMED;
                    wd_nx    = '0;
                end
            end
            default: begin
                state_nx = S_DISARMED;
                wd_nx    = '0;
            end
        endcase
        if (!arm) begin
            state_nx   = S_DISARMED;
            wd_nx      = '0;
            clear_vals = 1'b0;
        end
    end

    // A write landing on the boundary cycle goes straight into the active set.
    always_ff @(posedge tmr_1Mhz) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clear_vals) begin
                    pending[i] <= '0;
                    active[i]  <= '0;
                end else begin
                    if (wr_hit[i]) begin
                        pending[i] <= wr_val;
                    end
                    if (boundary) begin
                        active[i] <= wr_hit[i] ? wr_val : pending[i];
                    end
                end
            end
        end
    end

    assign out_en = (state != S_DISARMED);
    assign out_fs = (state == S_FAILSAFE);

    always_comb begin
        logic [CMP_W-1:0] width;
        width = '0;
        high  = '0;
        for (int i = 0; i < NCH; i++) begin
            width = out_fs ? W_MIN : (W_MIN + CMP_W'(active[i]));
            if (width > W_MAX) begin
                width = W_MAX;
            end
            high[i] = out_en && (CMP_W'(ctr) < width);
        end
    end

    always_ff @(posedge tmr_1Mhz) begin
        if (!rst) begin
            sig        <= '0;
            frame_tick <= 1'b0;
        end else begin
            sig        <= high;
            frame_tick <= (ctr == '0);
        end
    end

    assign armed    = out_en;
    assign failsafe = out_fs;

endmodule

// File: tb/tb_esc_multi.sv
// Bench for esc_multi: frame-level reference model feeds an expected queue;
// a monitor measures each frame's pulse widths and flags and compares.
module tb_esc_multi;

    localparam int NCH            = 5;
    localparam int VAL_W          = 6;
    localparam int PERIOD         = 100;
    localparam int PULSE_MIN      = 40;
    localparam int TIMEOUT_FRAMES = 4;
    localparam int CH_W           = 3;
    localparam int SW             = 16;
    localparam int W              = NCH * SW + 2;
    localparam int M_DIS          = 0;
    localparam int M_ARM          = 1;
    localparam int M_FS           = 2;

    logic             tmr_1Mhz = 1'b0;
    logic             rst      = 1'b0;
    logic             arm      = 1'b0;
    logic             wr_en    = 1'b0;
    logic [CH_W-1:0]  wr_ch    = '0;
    logic [VAL_W-1:0] wr_val   = '0;
    logic [NCH-1:0]   sig;
    logic             frame_tick;
    logic             armed;
    logic             failsafe;

    always #5 tmr_1Mhz = ~tmr_1Mhz;

    esc_multi #(
        .NCH(NCH), .VAL_W(VAL_W), .PERIOD(PERIOD),
        .PULSE_MIN(PULSE_MIN), .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) dut (
        .tmr_1Mhz(tmr_1Mhz), .rst(rst), .arm(arm), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_val(wr_val), .sig(sig), .frame_tick(frame_tick),
        .armed(armed), .failsafe(failsafe)
    );

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    bit         mon_en = 0;
    bit         have_frame = 0;
    int         gap = 0;
    int         mon_frame = 0;
    int         cnt[NCH];
    logic [1:0] flags_cap;

    int m_mode = M_DIS;
    int m_cnt  = 0;
    int m_pend[NCH];
    int m_act[NCH];

    // Per-frame stimulus plan: arm level in three spans, up to four writes.
    bit p_l0, p_l1, p_l2;
    int p_s1, p_s2, p_nw;
    int p_wc[4];
    int p_wch[4];
    int p_wv[4];

    function automatic bit arm_at(int c);
        return (c < p_s1) ? p_l0 : ((c < p_s2) ? p_l1 : p_l2);
    endfunction

    function automatic int clamp_w(int w);
        return (w > PERIOD - 1) ? PERIOD - 1 : w;
    endfunction

    function automatic int first_drop();
        for (int c = 0; c < PERIOD; c++) begin
            if (!arm_at(c)) return c;
        end
        return -1;
    endfunction

    task automatic check(string name, int got, int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic plan(input bit l0, input bit l1, input bit l2, input int s1, input int s2);
        p_l0 = l0; p_l1 = l1; p_l2 = l2; p_s1 = s1; p_s2 = s2; p_nw = 0;
    endtask

    task automatic add_wr(input int c, input int ch, input int v);
        p_wc[p_nw] = c; p_wch[p_nw] = ch; p_wv[p_nw] = v;
        p_nw++;
    endtask

    task automatic model_start();
        logic [W-1:0] e;
        int k, w, ex, first_mode;
        e = '0;
        k = first_drop();
        for (int ch = 0; ch < NCH; ch++) begin
            w = (m_mode == M_FS) ? clamp_w(PULSE_MIN) : clamp_w(PULSE_MIN + m_act[ch]);
            if (m_mode == M_DIS) ex = 0;
            else if (k >= 0 && k + 1 < w) ex = k + 1;
            else ex = w;
            e[ch*SW +: SW] = 16'(ex);
        end
        first_mode = arm_at(0) ? m_mode : M_DIS;
        e[W-1] = (first_mode != M_DIS);
        e[W-2] = (first_mode == M_FS);
        exp_q.push_back(e);
    endtask

    task automatic model_end();
        int k, pre_mode, pre_cnt;
        bit arm_end, any_wr, wr_bnd;
        k = first_drop();
        arm_end = arm_at(PERIOD - 1);
        any_wr = 0;
        wr_bnd = 0;
        for (int j = 0; j < p_nw; j++) begin
            if (p_wch[j] < NCH) begin
                m_pend[p_wch[j]] = p_wv[j];
                any_wr = 1;
                if (p_wc[j] == PERIOD - 1) wr_bnd = 1;
            end
        end
        if (!arm_end) begin
            m_mode = M_DIS; m_cnt = 0;
        end else if (m_mode == M_DIS || k >= 0) begin
            m_mode = M_ARM; m_cnt = 0;
        end else begin
            pre_mode = any_wr ? M_ARM : m_mode;
            pre_cnt  = any_wr ? 0 : m_cnt;
            if (wr_bnd) begin
                m_mode = M_ARM; m_cnt = 0;
            end else if (pre_mode == M_FS) begin
                m_mode = M_FS;
            end else begin
                m_cnt = (TIMEOUT_FRAMES > 0) ?
                        ((pre_cnt + 1 > TIMEOUT_FRAMES) ? TIMEOUT_FRAMES : pre_cnt + 1) : 0;
                if (TIMEOUT_FRAMES > 0 && m_cnt >= TIMEOUT_FRAMES) begin
                    m_mode = M_FS;
                    for (int ch = 0; ch < NCH; ch++) m_pend[ch] = 0;
                end else begin
                    m_mode = M_ARM;
                end
            end
        end
        for (int ch = 0; ch < NCH; ch++) m_act[ch] = m_pend[ch];
    endtask

    task automatic drive_cycles(input int from, input int to);
        for (int c = from; c < to; c++) begin
            arm = arm_at(c);
            wr_en = 1'b0; wr_ch = '0; wr_val = '0;
            for (int j = 0; j < p_nw; j++) begin
                if (p_wc[j] == c) begin
                    wr_en = 1'b1; wr_ch = CH_W'(p_wch[j]); wr_val = VAL_W'(p_wv[j]);
                end
            end
            @(posedge tmr_1Mhz);
            @(negedge tmr_1Mhz);
        end
    endtask

    task automatic drive_frame();
        model_start();
        drive_cycles(0, PERIOD);
        model_end();
    endtask

    task automatic do_reset();
        mon_en = 0;
        exp_q.delete();
        rst = 1'b0; arm = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge tmr_1Mhz);
            @(negedge tmr_1Mhz);
            check("reset sig", int'(sig), 0);
            check("reset flags", int'({frame_tick, armed, failsafe}), 0);
        end
        m_mode = M_DIS; m_cnt = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_pend[ch] = 0; m_act[ch] = 0;
        end
        have_frame = 0;
        rst = 1'b1;
        mon_en = 1;
    endtask

    task automatic finish_frame();
        logic [W-1:0] e;
        check($sformatf("frame%0d tick gap", mon_frame), gap, PERIOD);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame%0d unexpected: got a frame, expected none queued", mon_frame);
        end else begin
            e = exp_q.pop_front();
            for (int ch = 0; ch < NCH; ch++) begin
                check($sformatf("frame%0d width ch%0d", mon_frame, ch), cnt[ch], int'(e[ch*SW +: SW]));
            end
            check($sformatf("frame%0d flags armed,failsafe", mon_frame), int'(flags_cap), int'(e[W-1 -: 2]));
        end
        mon_frame++;
    endtask

    // Each frame spans from one frame_tick to the next; count high cycles per channel.
    always @(negedge tmr_1Mhz) begin
        if (mon_en) begin
            if (frame_tick) begin
                if (have_frame) finish_frame();
                have_frame = 1;
                gap = 0;
                flags_cap = {armed, failsafe};
                for (int ch = 0; ch < NCH; ch++) cnt[ch] = 0;
            end
            gap++;
            for (int ch = 0; ch < NCH; ch++) cnt[ch] += int'(sig[ch]);
        end
    end

    initial begin
        #5000000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int nw;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            plan(0, 0, 0, PERIOD, PERIOD);
            drive_frame();
        end
        plan(0, 1, 1, 30, PERIOD);
        add_wr(40, 0, 0); add_wr(50, 1, 63); add_wr(60, 2, 32);
        drive_frame();
        plan(1, 1, 1, PERIOD, PERIOD);
        add_wr(50, 1, 10); add_wr(PERIOD - 1, 1, 20);
        drive_frame();
        plan(1, 1, 1, PERIOD, PERIOD); add_wr(30, 7, 5);
        drive_frame();
        plan(1, 1, 1, PERIOD, PERIOD); add_wr(20, 6, 9);
        drive_frame();
        for (int f = 0; f < 2; f++) begin
            plan(1, 1, 1, PERIOD, PERIOD);
            drive_frame();
        end
        plan(1, 1, 1, PERIOD, PERIOD); add_wr(50, 0, 30);
        drive_frame();
        plan(1, 1, 1, PERIOD, PERIOD);
        drive_frame();
        plan(1, 1, 1, PERIOD, PERIOD); add_wr(10, 2, 32);
        drive_frame();
        plan(1, 0, 1, 40, 70);
        drive_frame();
        for (int f = 0; f < 3; f++) begin
            plan(1, 1, 1, PERIOD, PERIOD);
            drive_frame();
        end
        plan(1, 1, 1, PERIOD, PERIOD); add_wr(PERIOD - 1, 3, 5);
        drive_frame();
        for (int f = 0; f < 3; f++) begin
            plan(1, 1, 1, PERIOD, PERIOD);
            drive_frame();
        end
        plan(1, 0, 0, PERIOD - 1, PERIOD);
        drive_frame();
        plan(0, 1, 1, 50, PERIOD);
        drive_frame();

        plan(1, 1, 1, PERIOD, PERIOD); add_wr(20, 4, 63);
        model_start();
        drive_cycles(0, 50);
        do_reset();
        plan(1, 1, 1, PERIOD, PERIOD);
        drive_frame();

        for (int f = 0; f < 30; f++) begin
            plan(urandom_bit(), urandom_bit(), urandom_bit(), 0, 0);
            p_s1 = $urandom_range(1, PERIOD);
            p_s2 = $urandom_range(p_s1, PERIOD);
            nw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            for (int j = 0; j < nw; j++) begin
                add_wr(1 + j * 33 + $urandom_range(0, 32), $urandom_range(0, 7), $urandom_range(0, 63));
            end
            if ($urandom_range(0, 5) == 0 && (p_nw == 0 || p_wc[p_nw-1] < PERIOD - 1)) begin
                add_wr(PERIOD - 1, $urandom_range(0, 7), $urandom_range(0, 63));
            end
            drive_frame();
        end

        arm = 1'b0; wr_en = 1'b0;
        repeat (3) begin
            @(posedge tmr_1Mhz);
            @(negedge tmr_1Mhz);
        end
        check("expected queue drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic bit urandom_bit();
        return ($urandom_range(0, 19) != 0);
    endfunction

endmodule
